lfsr_sram_ctrl: RTL and testbench
=================================

Name: lfsr_sram_ctrl

Overview:
Sequencer for the LFSR-hash / counting-SRAM datapath. It accepts one k-mer descriptor at a time from the k-mer generator and drives the datapath strobes (en_lfsr, read_add, get_row, set_row). It also drives the active-low controls of the dual-port counter SRAMs: port 1 reads, port 2 writes. It serializes the read-modify-write of each k-mer, so a write always completes before the next read, and it drops out-of-range positions.

Parameters:
READ_LAT, 1, SRAM port-1 read latency in cycles (1..4).
MAX_POS, 212, positions >= MAX_POS are hashed but not written.
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
enable  in  1  allows new k-mers to be accepted.
kmer_valid  in  1  k-mer descriptor valid.
kmer_pos  in  8  k-mer position (rg_out[97:90]).
kmer_last  in  1  marks the final k-mer of a read.
kmer_ready  out  1  controller accepts a k-mer this cycle.
en_lfsr  out  1  hash/LFSR update strobe.
read_add  out  1  address latch strobe.
get_row  out  1  capture SRAM read data strobe.
set_row  out  1  compute write data strobe.
csb1, oeb1, web1  out  1 each  port-1 (read) controls, active-low.
csb2, oeb2, web2  out  1 each  port-2 (write) controls, active-low.
busy  out  1  high when the FSM is not in IDLE.
done  out  1  one-cycle pulse after the last k-mer completes.
kmer_cnt  out  CNT_W  k-mers written, saturating.
drop_cnt  out  CNT_W  k-mers dropped, saturating.

Behaviour:
- Reset (async, active-high): FSM to IDLE. All strobes 0. csb1/oeb1/web1/csb2/oeb2/web2 = 1. done=0. Counters=0. Latched pos and last flags = 0. Reset mid-operation abandons the k-mer with no write issued.
- All outputs are registered/Moore from the state, except kmer_ready = (state==IDLE) & enable.
- Accept when kmer_valid & kmer_ready. Latch kmer_pos and kmer_last. Set drop = (kmer_pos >= MAX_POS).
- States and the outputs asserted in each:
  - IDLE: no strobes.
  - HASH (1 cycle): en_lfsr=1.
  - ADDR (1 cycle): read_add=1.
  - READ (READ_LAT cycles, down-counter): csb1=0, oeb1=0, web1=1.
  - GET (1 cycle): get_row=1, csb1=0, oeb1=0.
  - SET (1 cycle): set_row=1.
  - WRITE (1 cycle): csb2=0, web2=0, oeb2=1.
- Transitions:
  - IDLE → HASH on accept.
  - HASH → IDLE if drop, otherwise HASH → ADDR. On the drop path drop_cnt increments; the LFSR still advances to keep the hash sequence aligned.
  - ADDR → READ → GET → SET → WRITE → IDLE. kmer_cnt increments on leaving WRITE.
- Timing with READ_LAT=1 (accept at edge 0): en_lfsr cycle 1, read_add cycle 2, csb1 low cycle 3, get_row cycle 4, set_row cycle 5, csb2/web2 low cycle 6. kmer_ready returns cycle 7, giving one k-mer per 7 cycles. A dropped k-mer gives ready again in cycle 2.
- done pulses the cycle after the terminal state (WRITE or dropped HASH) of a k-mer latched with last=1.
- Invariants:
  - en_lfsr and read_add are never high together.
  - Port 1 and port 2 are never both selected.
  - web1 is always 1.
  - At most one of en_lfsr/read_add/get_row/set_row is high per cycle.
- Deasserting enable mid-operation has no effect on the current k-mer; it only blocks the next accept.
- Counters hold at 2^CNT_W-1 (saturate, no wrap).

Test Plan:
- Reset mid-WRITE: assert reset during cycle 6 → csb2=web2=1 immediately (asynchronous), state IDLE, kmer_cnt=0, no done pulse.
- Single k-mer, pos=10, last=1, READ_LAT=1 → strobes exactly in cycles 1/2/3/4/5/6 as listed. kmer_cnt=1, done pulse in cycle 7, kmer_ready=1 in cycle 7.
- Back-to-back k-mers with kmer_valid held high, positions 0..4 → 5 writes, accepts exactly 7 cycles apart, port-1 and port-2 selects never overlap, kmer_cnt=5.
- pos=212 then pos=211 → first: en_lfsr only, drop_cnt=1, no csb1/csb2 activity. Second: full write, kmer_cnt=1.
- READ_LAT=3 → csb1/oeb1 low for 3 cycles, then get_row in cycle 6 and WRITE in cycle 8.
- Force kmer_cnt to 0xFFFE, then run 3 k-mers → counter reads 0xFFFF (saturated). Drop enable during HASH → current k-mer completes and kmer_ready stays 0 afterwards.

Source files
------------

// File: rtl/lfsr_sram_ctrl_if.sv
// K-mer handshake, datapath strobes and dual-port SRAM controls for the LFSR/SRAM sequencer.
// The controller side uses the slave modport; the k-mer source and datapath side uses master.
interface lfsr_sram_ctrl_if;
  logic       kmer_valid;
  logic [7:0] kmer_pos;
  logic       kmer_last;
  logic       kmer_ready;
  logic       en_lfsr;
  logic       read_add;
  logic       get_row;
  logic       set_row;
  logic       csb1;
  logic       oeb1;
  logic       web1;
  logic       csb2;
  logic       oeb2;
  logic       web2;

  modport master (
    output kmer_valid, kmer_pos, kmer_last,
    input  kmer_ready, en_lfsr, read_add, get_row, set_row,
    input  csb1, oeb1, web1, csb2, oeb2, web2
  );

  modport slave (
    input  kmer_valid, kmer_pos, kmer_last,
    output kmer_ready, en_lfsr, read_add, get_row, set_row,
    output csb1, oeb1, web1, csb2, oeb2, web2
  );
endinterface

// File: rtl/lfsr_sram_ctrl.sv
// Sequencer for the LFSR-hash / counting-SRAM datapath: one read-modify-write per k-mer,
// with out-of-range positions hashed but never written.
module lfsr_sram_ctrl #(
  parameter int READ_LAT = 1,
  parameter int MAX_POS  = 212,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  lfsr_sram_ctrl_if.slave  bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] kmer_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {IDLE, HASH, ADDR, READ, GET, SET, WRITE} state_t;

  localparam logic [8:0] MAX_POS_W = 9'(MAX_POS);
  localparam logic [1:0] LAT_LOAD  = 2'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state;
  state_t     state_nxt;
  logic [7:0] pos_q;
  logic       last_q;
  logic [1:0] lat_cnt;
  logic       ready;
  logic       accept;
  logic       drop;

  assign ready  = (state == IDLE) && enable;
  assign accept = bus.kmer_valid && ready;
  assign drop   = ({1'b0, pos_q} >= MAX_POS_W);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = HASH;
      HASH:    state_nxt = drop ? IDLE : ADDR;
      ADDR:    state_nxt = READ;
      READ:    if (lat_cnt == 2'd0) state_nxt = GET;
      GET:     state_nxt = SET;
      SET:     state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore decode; SRAM controls idle high so an async reset releases both ports at once.
  always_comb begin
    bus.kmer_ready = ready;
    bus.en_lfsr    = 1'b0;
    bus.read_add   = 1'b0;
    bus.get_row    = 1'b0;
    bus.set_row    = 1'b0;
    bus.csb1       = 1'b1;
    bus.oeb1       = 1'b1;
    bus.web1       = 1'b1;
    bus.csb2       = 1'b1;
    bus.oeb2       = 1'b1;
    bus.web2       = 1'b1;
    case (state)
      HASH: bus.en_lfsr  = 1'b1;
      ADDR: bus.read_add = 1'b1;
      READ: begin
        bus.csb1 = 1'b0;
        bus.oeb1 = 1'b0;
      end
      GET: begin
        bus.get_row = 1'b1;
        bus.csb1    = 1'b0;
        bus.oeb1    = 1'b0;
      end
      SET:   bus.set_row = 1'b1;
      WRITE: begin
        bus.csb2 = 1'b0;
        bus.web2 = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q  <= 8'd0;
      last_q <= 1'b0;
    end else if (accept) begin
      pos_q  <= bus.kmer_pos;
      last_q <= bus.kmer_last;
    end
  end

  // Loaded one cycle early so READ lasts exactly READ_LAT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    lat_cnt <= 2'd0;
    else if (state == ADDR)                       lat_cnt <= LAT_LOAD;
    else if (state == READ && lat_cnt != 2'd0)    lat_cnt <= lat_cnt - 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kmer_cnt <= '0;
      drop_cnt <= '0;
      done     <= 1'b0;
    end else begin
      if (state == WRITE && kmer_cnt != CNT_MAX)        kmer_cnt <= kmer_cnt + 1'b1;
      if (state == HASH && drop && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
      done <= last_q && ((state == WRITE) || (state == HASH && drop));
    end
  end

endmodule

// File: tb/tb_lfsr_sram_ctrl.sv
// Self-checking bench for lfsr_sram_ctrl: per-cycle strobe schedule, counters and done
// compared against a cycle-offset model of the k-mer sequence.
module tb_lfsr_sram_ctrl;
  localparam int MAX_POS = 212;

  logic clk;
  logic reset;
  logic enable_a, enable_b, enable_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic [15:0] kcnt_a, dcnt_a, kcnt_b, dcnt_b;
  logic [1:0]  kcnt_c, dcnt_c;
  int tests = 0;
  int fails = 0;
  int exp_k_a = 0, exp_d_a = 0, exp_k_b = 0, exp_k_c = 0, exp_d_c = 0;

  lfsr_sram_ctrl_if bus_a ();
  lfsr_sram_ctrl_if bus_b ();
  lfsr_sram_ctrl_if bus_c ();

  lfsr_sram_ctrl #(.READ_LAT(1), .MAX_POS(212), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .bus(bus_a),
    .busy(busy_a), .done(done_a), .kmer_cnt(kcnt_a), .drop_cnt(dcnt_a));
  lfsr_sram_ctrl #(.READ_LAT(3), .MAX_POS(212), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .bus(bus_b),
    .busy(busy_b), .done(done_b), .kmer_cnt(kcnt_b), .drop_cnt(dcnt_b));
  lfsr_sram_ctrl #(.READ_LAT(2), .MAX_POS(212), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .enable(enable_c), .bus(bus_c),
    .busy(busy_c), .done(done_c), .kmer_cnt(kcnt_c), .drop_cnt(dcnt_c));

  wire [10:0] obs_a = {bus_a.en_lfsr, bus_a.read_add, bus_a.get_row, bus_a.set_row, bus_a.csb1,
                       bus_a.oeb1, bus_a.web1, bus_a.csb2, bus_a.oeb2, bus_a.web2, busy_a};
  wire [10:0] obs_b = {bus_b.en_lfsr, bus_b.read_add, bus_b.get_row, bus_b.set_row, bus_b.csb1,
                       bus_b.oeb1, bus_b.web1, bus_b.csb2, bus_b.oeb2, bus_b.web2, busy_b};
  wire [10:0] obs_c = {bus_c.en_lfsr, bus_c.read_add, bus_c.get_row, bus_c.set_row, bus_c.csb1,
                       bus_c.oeb1, bus_c.web1, bus_c.csb2, bus_c.oeb2, bus_c.web2, busy_c};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {en_lfsr,read_add,get_row,set_row,csb1,oeb1,web1,csb2,oeb2,web2,busy}
  // 'off' cycles after the accepting edge.
  function automatic logic [10:0] exp_vec(int off, int pos, int lat);
    logic en, ra, gr, sr, c1, c2, bz;
    en = (off == 1);
    ra = 1'b0; gr = 1'b0; sr = 1'b0; c1 = 1'b1; c2 = 1'b1;
    if (pos >= MAX_POS) begin
      bz = (off == 1);
    end else begin
      bz = (off >= 1 && off <= 5 + lat);
      ra = (off == 2);
      gr = (off == 3 + lat);
      sr = (off == 4 + lat);
      c1 = !(off >= 3 && off <= 3 + lat);
      c2 = !(off == 5 + lat);
    end
    return {en, ra, gr, sr, c1, c1, 1'b1, c2, 1'b1, c2, bz};
  endfunction

  function automatic int end_off(int pos, int lat);
    return (pos >= MAX_POS) ? 2 : 6 + lat;
  endfunction

  function automatic int sat_inc(int v, int w);
    return (v >= (1 << w) - 1) ? (1 << w) - 1 : v + 1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (obs_a !== exp_vec(0, 0, 1) || obs_b !== exp_vec(0, 0, 3) || obs_c !== exp_vec(0, 0, 2)) begin
      fails++; $display("[TB] FAIL reset_outputs: got %b/%b/%b want %b", obs_a, obs_b, obs_c, exp_vec(0, 0, 1));
    end
    tests++;
    if (kcnt_a !== 16'd0 || dcnt_a !== 16'd0 || kcnt_c !== 2'd0 || done_a !== 1'b0 || done_b !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_counters: got k=%0d d=%0d kc=%0d done=%b want 0", kcnt_a, dcnt_a, kcnt_c, done_a);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (bus_a.kmer_ready !== 1'b1 || obs_a !== exp_vec(0, 0, 1)) begin
      fails++; $display("[TB] FAIL reset_release: ready=%b vec=%b want ready=1 vec=%b", bus_a.kmer_ready, obs_a, exp_vec(0, 0, 1));
    end
  endtask

  task automatic test_single();
    int eo;
    eo = end_off(10, 1);
    @(negedge clk);
    bus_a.kmer_valid = 1'b1; bus_a.kmer_pos = 8'd10; bus_a.kmer_last = 1'b1;
    #1;
    tests++;
    if (bus_a.kmer_ready !== 1'b1) begin fails++; $display("[TB] FAIL single_ready0: got %b want 1", bus_a.kmer_ready); end
    for (int off = 1; off <= eo; off++) begin
      @(negedge clk);
      if (off == 1) bus_a.kmer_valid = 1'b0;
      tests++;
      if (obs_a !== exp_vec(off, 10, 1) || done_a !== (off == eo) || bus_a.kmer_ready !== (off == eo)) begin
        fails++; $display("[TB] FAIL single cyc%0d: got vec=%b done=%b rdy=%b want vec=%b done=%b", off, obs_a, done_a, bus_a.kmer_ready, exp_vec(off, 10, 1), off == eo);
      end
    end
    exp_k_a = sat_inc(exp_k_a, 16);
    tests++;
    if (kcnt_a !== 16'(exp_k_a)) begin fails++; $display("[TB] FAIL single_kcnt: got %0d want %0d", kcnt_a, exp_k_a); end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t <= 35; t++) begin
      @(negedge clk);
      bus_a.kmer_valid = (t < 35); bus_a.kmer_pos = 8'(t / 7); bus_a.kmer_last = 1'b0;
      #1;
      tests++;
      if (obs_a !== exp_vec(t % 7, t / 7, 1) || bus_a.kmer_ready !== (t % 7 == 0) || done_a !== 1'b0) begin
        fails++; $display("[TB] FAIL b2b cyc%0d: got vec=%b rdy=%b want vec=%b rdy=%b", t, obs_a, bus_a.kmer_ready, exp_vec(t % 7, t / 7, 1), t % 7 == 0);
      end
      tests++;
      if (!bus_a.csb1 && !bus_a.csb2) begin fails++; $display("[TB] FAIL b2b_ports cyc%0d: got csb1=0 csb2=0 want not both", t); end
    end
    exp_k_a = exp_k_a + 5;
    tests++;
    if (kcnt_a !== 16'(exp_k_a)) begin fails++; $display("[TB] FAIL b2b_kcnt: got %0d want %0d", kcnt_a, exp_k_a); end
  endtask

  task automatic test_drop();
    int plist [2] = '{212, 211};
    for (int k = 0; k < 2; k++) begin
      int p, eo;
      p = plist[k]; eo = end_off(p, 1);
      @(negedge clk);
      bus_a.kmer_valid = 1'b1; bus_a.kmer_pos = 8'(p); bus_a.kmer_last = 1'b0;
      for (int off = 1; off <= eo; off++) begin
        @(negedge clk);
        if (off == 1) bus_a.kmer_valid = 1'b0;
        tests++;
        if (obs_a !== exp_vec(off, p, 1) || bus_a.kmer_ready !== (off == eo)) begin
          fails++; $display("[TB] FAIL drop pos%0d cyc%0d: got vec=%b rdy=%b want vec=%b", p, off, obs_a, bus_a.kmer_ready, exp_vec(off, p, 1));
        end
      end
      if (p >= MAX_POS) exp_d_a = sat_inc(exp_d_a, 16);
      else              exp_k_a = sat_inc(exp_k_a, 16);
      tests++;
      if (kcnt_a !== 16'(exp_k_a) || dcnt_a !== 16'(exp_d_a)) begin
        fails++; $display("[TB] FAIL drop_cnts pos%0d: got k=%0d d=%0d want k=%0d d=%0d", p, kcnt_a, dcnt_a, exp_k_a, exp_d_a);
      end
    end
  endtask

  task automatic test_read_lat3();
    int eo;
    eo = end_off(50, 3);
    @(negedge clk);
    bus_b.kmer_valid = 1'b1; bus_b.kmer_pos = 8'd50; bus_b.kmer_last = 1'b1;
    for (int off = 1; off <= eo; off++) begin
      @(negedge clk);
      if (off == 1) bus_b.kmer_valid = 1'b0;
      tests++;
      if (obs_b !== exp_vec(off, 50, 3) || done_b !== (off == eo)) begin
        fails++; $display("[TB] FAIL lat3 cyc%0d: got vec=%b done=%b want vec=%b done=%b", off, obs_b, done_b, exp_vec(off, 50, 3), off == eo);
      end
    end
    exp_k_b = sat_inc(exp_k_b, 16);
    tests++;
    if (kcnt_b !== 16'(exp_k_b)) begin fails++; $display("[TB] FAIL lat3_kcnt: got %0d want %0d", kcnt_b, exp_k_b); end
  endtask

  task automatic test_saturation();
    int plist [9] = '{1, 2, 250, 3, 212, 4, 240, 230, 5};
    for (int k = 0; k < 9; k++) begin
      int p, eo;
      p = plist[k]; eo = end_off(p, 2);
      @(negedge clk);
      bus_c.kmer_valid = 1'b1; bus_c.kmer_pos = 8'(p); bus_c.kmer_last = 1'b0;
      for (int off = 1; off <= eo; off++) begin
        @(negedge clk);
        if (off == 1) bus_c.kmer_valid = 1'b0;
        tests++;
        if (obs_c !== exp_vec(off, p, 2)) begin
          fails++; $display("[TB] FAIL sat_vec pos%0d cyc%0d: got %b want %b", p, off, obs_c, exp_vec(off, p, 2));
        end
      end
      if (p >= MAX_POS) exp_d_c = sat_inc(exp_d_c, 2);
      else              exp_k_c = sat_inc(exp_k_c, 2);
      tests++;
      if (kcnt_c !== 2'(exp_k_c) || dcnt_c !== 2'(exp_d_c)) begin
        fails++; $display("[TB] FAIL sat_cnts k%0d: got k=%0d d=%0d want k=%0d d=%0d", k, kcnt_c, dcnt_c, exp_k_c, exp_d_c);
      end
    end
  endtask

  task automatic test_enable_drop();
    int eo;
    eo = end_off(30, 1);
    @(negedge clk);
    bus_a.kmer_valid = 1'b1; bus_a.kmer_pos = 8'd30; bus_a.kmer_last = 1'b0;
    for (int off = 1; off <= eo + 3; off++) begin
      @(negedge clk);
      if (off == 1) begin enable_a = 1'b0; bus_a.kmer_pos = 8'd31; end
      #1;
      tests++;
      if (obs_a !== exp_vec(off, 30, 1) || bus_a.kmer_ready !== 1'b0) begin
        fails++; $display("[TB] FAIL en_drop cyc%0d: got vec=%b rdy=%b want vec=%b rdy=0", off, obs_a, bus_a.kmer_ready, exp_vec(off, 30, 1));
      end
    end
    exp_k_a = sat_inc(exp_k_a, 16);
    tests++;
    if (kcnt_a !== 16'(exp_k_a)) begin fails++; $display("[TB] FAIL en_drop_kcnt: got %0d want %0d", kcnt_a, exp_k_a); end
    bus_a.kmer_valid = 1'b0;
    enable_a = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      int p, eo, gap;
      logic l;
      p   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(205, 220)) : int'($urandom_range(0, 255));
      l   = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2);
      eo  = end_off(p, 1);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        enable_a = 1'b0; bus_a.kmer_valid = 1'b1; bus_a.kmer_pos = 8'(p);
        #1;
        tests++;
        if (bus_a.kmer_ready !== 1'b0 || obs_a !== exp_vec(0, p, 1)) begin
          fails++; $display("[TB] FAIL rand_gap k%0d: got rdy=%b vec=%b want rdy=0 vec=%b", k, bus_a.kmer_ready, obs_a, exp_vec(0, p, 1));
        end
      end
      @(negedge clk);
      enable_a = 1'b1; bus_a.kmer_valid = 1'b1; bus_a.kmer_pos = 8'(p); bus_a.kmer_last = l;
      #1;
      tests++;
      if (bus_a.kmer_ready !== 1'b1 || obs_a !== exp_vec(0, p, 1) || done_a !== 1'b0) begin
        fails++; $display("[TB] FAIL rand_start k%0d: got rdy=%b vec=%b done=%b want rdy=1 idle", k, bus_a.kmer_ready, obs_a, done_a);
      end
      for (int off = 1; off <= eo; off++) begin
        @(negedge clk);
        if (off == 1) bus_a.kmer_valid = 1'b0;
        tests++;
        if (obs_a !== exp_vec(off, p, 1) || done_a !== (l && off == eo) || bus_a.kmer_ready !== (off == eo)) begin
          fails++; $display("[TB] FAIL rand k%0d pos%0d cyc%0d: got vec=%b done=%b want vec=%b done=%b", k, p, off, obs_a, done_a, exp_vec(off, p, 1), l && off == eo);
        end
      end
      if (p >= MAX_POS) exp_d_a = sat_inc(exp_d_a, 16);
      else              exp_k_a = sat_inc(exp_k_a, 16);
      tests++;
      if (kcnt_a !== 16'(exp_k_a) || dcnt_a !== 16'(exp_d_a)) begin
        fails++; $display("[TB] FAIL rand_cnts k%0d: got k=%0d d=%0d want k=%0d d=%0d", k, kcnt_a, dcnt_a, exp_k_a, exp_d_a);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    bus_a.kmer_valid = 1'b1; bus_a.kmer_pos = 8'd20; bus_a.kmer_last = 1'b1;
    for (int off = 1; off <= 6; off++) begin
      @(negedge clk);
      if (off == 1) bus_a.kmer_valid = 1'b0;
      tests++;
      if (obs_a !== exp_vec(off, 20, 1)) begin
        fails++; $display("[TB] FAIL rstw cyc%0d: got %b want %b", off, obs_a, exp_vec(off, 20, 1));
      end
    end
    reset = 1'b1;
    #1;
    exp_k_a = 0; exp_d_a = 0; exp_k_b = 0; exp_k_c = 0; exp_d_c = 0;
    tests++;
    if (bus_a.csb2 !== 1'b1 || bus_a.web2 !== 1'b1 || busy_a !== 1'b0 || kcnt_a !== 16'(exp_k_a) || kcnt_c !== 2'(exp_k_c)) begin
      fails++; $display("[TB] FAIL rstw_async: got csb2=%b web2=%b busy=%b kcnt=%0d want 1 1 0 0", bus_a.csb2, bus_a.web2, busy_a, kcnt_a);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (done_a !== 1'b0 || obs_a !== exp_vec(0, 0, 1) || kcnt_a !== 16'(exp_k_a)) begin
        fails++; $display("[TB] FAIL rstw_after cyc%0d: got done=%b vec=%b kcnt=%0d want done=0 idle 0", c, done_a, obs_a, kcnt_a);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    enable_a = 1'b1; enable_b = 1'b1; enable_c = 1'b1;
    bus_a.kmer_valid = 1'b0; bus_a.kmer_pos = 8'd0; bus_a.kmer_last = 1'b0;
    bus_b.kmer_valid = 1'b0; bus_b.kmer_pos = 8'd0; bus_b.kmer_last = 1'b0;
    bus_c.kmer_valid = 1'b0; bus_c.kmer_pos = 8'd0; bus_c.kmer_last = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_read_lat3();
    test_saturation();
    test_enable_drop();
    test_random();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
